// File: rtl/fm_wb_collector.sv
// fm_wb_collector
//   Collects a PE-row write-back byte stream and (optionally) a guard stream
//   and writes them to memory through one shared write port.
//   Bytes are packed little-endian into 32-bit words. The final partial word
//   carries byte enables only for the bytes that were actually written.
//   Guards are written one per word as {26'b0, guard}.
//
// Configuration macro:
//   FM_WB_GUARD_EN - when defined, the guard channel is built.
//                    When undefined, guard_ready_o is tied high, guard_i is
//                    discarded, and the job completes on the byte count alone.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   start_i                     one-cycle job start (sampled in IDLE only)
//   data_base_i, guard_base_i   region word addresses (latched on start)
//   byte_num_i, guard_num_i     expected byte / guard counts (latched on start)
//   wb_data_i/valid_i/ready_o   write-back byte stream
//   guard_i/valid_i/ready_o     guard stream
//   mem_req_o/addr_o/wdata_o/be_o, mem_gnt_i
//                               shared write port; a write completes when
//                               req and gnt are both high
//   done_o                      one-cycle completion pulse
//   busy_o                      high outside IDLE
module fm_wb_collector #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] data_base_i,
  input  logic [ADDR_W-1:0] guard_base_i,
  input  logic [CNT_W-1:0]  byte_num_i,
  input  logic [CNT_W-1:0]  guard_num_i,
  input  logic [7:0]        wb_data_i,
  input  logic              wb_valid_i,
  output logic              wb_ready_o,
  input  logic [5:0]        guard_i,
  input  logic              guard_valid_i,
  output logic              guard_ready_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_be_o,
  input  logic              mem_gnt_i,
  output logic              done_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  state_e state_q, state_d;

  // data channel
  logic [CNT_W-1:0]  byte_num_q, byte_num_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0] data_addr_q, data_addr_d;
  logic [31:0]       pack_q, pack_d;
  logic [2:0]        pack_cnt_q, pack_cnt_d;
  logic              dpend_valid_q, dpend_valid_d;
  logic [31:0]       dpend_data_q, dpend_data_d;
  logic [3:0]        dpend_be_q, dpend_be_d;

  // guard channel view shared with the arbiter and FSM
  logic              gpend_valid;
  logic [5:0]        gpend_data;
  logic [ADDR_W-1:0] guard_addr;
  logic              guard_cnt_done;

  // arbitration
  logic prio_q, prio_d;
  logic hold_q, hold_d;
  logic sel_q, sel_d;
  logic sel_guard;
  logic mem_req;
  logic data_gnt;
  logic guard_gnt;

  logic start_job;
  logic byte_cnt_done;
  logic pack_full;
  logic pack_move;
  logic byte_take;
  logic [3:0] pack_be;

  assign start_job     = (state_q == IDLE) && start_i;
  assign byte_cnt_done = (byte_cnt_q == byte_num_q);
  assign pack_full     = (pack_cnt_q == 3'd4);

  assign wb_ready_o = (state_q == RUN) && !byte_cnt_done && !(pack_full && dpend_valid_q);
  assign byte_take  = wb_valid_i && wb_ready_o;

  // A full pack, or the leftover bytes once the count is reached, moves into
  // the pending register whenever that register is empty or is being granted
  // in this very cycle, so a back-to-back stream never loses a slot.
  assign pack_move = ((state_q == RUN) || (state_q == FLUSH)) &&
                     (!dpend_valid_q || data_gnt) &&
                     (pack_full || ((pack_cnt_q != 3'd0) && byte_cnt_done));

  always_comb begin
    pack_be = 4'hF;
    case (pack_cnt_q)
      3'd1:    pack_be = 4'h1;
      3'd2:    pack_be = 4'h3;
      3'd3:    pack_be = 4'h7;
      default: pack_be = 4'hF;
    endcase
  end

  // Once a request has been shown without a grant, the selection is frozen
  // so the port contents stay stable until the grant arrives.
  always_comb begin
    sel_guard = 1'b0;
    if (hold_q) begin
      sel_guard = sel_q;
    end else if (dpend_valid_q && gpend_valid) begin
      sel_guard = prio_q;
    end else begin
      sel_guard = gpend_valid;
    end
    mem_req     = dpend_valid_q || gpend_valid;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (mem_req) begin
      if (sel_guard) begin
        mem_addr_o  = guard_addr;
        mem_wdata_o = {26'b0, gpend_data};
        mem_be_o    = 4'hF;
      end else begin
        mem_addr_o  = data_addr_q;
        mem_wdata_o = dpend_data_q;
        mem_be_o    = dpend_be_q;
      end
    end
    data_gnt  = mem_req && mem_gnt_i && !sel_guard;
    guard_gnt = mem_req && mem_gnt_i && sel_guard;
  end

  assign mem_req_o = mem_req;

  // prio_q high means the guard channel wins the next conflict.
  always_comb begin
    prio_d = prio_q;
    hold_d = mem_req && !mem_gnt_i;
    sel_d  = sel_guard;
    if (start_job) begin
      prio_d = 1'b0;
    end else if (data_gnt) begin
      prio_d = 1'b1;
    end else if (guard_gnt) begin
      prio_d = 1'b0;
    end
  end

  always_comb begin
    byte_num_d    = byte_num_q;
    byte_cnt_d    = byte_cnt_q;
    data_addr_d   = data_addr_q;
    pack_d        = pack_q;
    pack_cnt_d    = pack_cnt_q;
    dpend_valid_d = dpend_valid_q;
    dpend_data_d  = dpend_data_q;
    dpend_be_d    = dpend_be_q;
    if (start_job) begin
      byte_num_d    = byte_num_i;
      byte_cnt_d    = '0;
      data_addr_d   = data_base_i;
      pack_d        = '0;
      pack_cnt_d    = '0;
      dpend_valid_d = 1'b0;
    end else begin
      if (data_gnt) begin
        dpend_valid_d = 1'b0;
        data_addr_d   = data_addr_q + ADDR_ONE;
      end
      if (pack_move) begin
        dpend_valid_d = 1'b1;
        dpend_data_d  = pack_q;
        dpend_be_d    = pack_be;
        pack_d        = '0;
        pack_cnt_d    = '0;
      end
      // pack_cnt_d is at most 3 here: a full pack either moved above or
      // held wb_ready_o low.
      if (byte_take) begin
        pack_d[{pack_cnt_d[1:0], 3'b000} +: 8] = wb_data_i;
        pack_cnt_d = pack_cnt_d + 3'd1;
        byte_cnt_d = byte_cnt_q + CNT_ONE;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = RUN;
      end
      RUN: begin
        if (byte_cnt_done && guard_cnt_done) state_d = FLUSH;
      end
      FLUSH: begin
        if ((pack_cnt_q == 3'd0) && (!dpend_valid_q || data_gnt) &&
            (!gpend_valid || guard_gnt)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign done_o = (state_q == DONE);
  assign busy_o = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      byte_num_q    <= '0;
      byte_cnt_q    <= '0;
      data_addr_q   <= '0;
      pack_q        <= '0;
      pack_cnt_q    <= '0;
      dpend_valid_q <= 1'b0;
      dpend_data_q  <= '0;
      dpend_be_q    <= '0;
      prio_q        <= 1'b0;
      hold_q        <= 1'b0;
      sel_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_num_q    <= byte_num_d;
      byte_cnt_q    <= byte_cnt_d;
      data_addr_q   <= data_addr_d;
      pack_q        <= pack_d;
      pack_cnt_q    <= pack_cnt_d;
      dpend_valid_q <= dpend_valid_d;
      dpend_data_q  <= dpend_data_d;
      dpend_be_q    <= dpend_be_d;
      prio_q        <= prio_d;
      hold_q        <= hold_d;
      sel_q         <= sel_d;
    end
  end

`ifdef FM_WB_GUARD_EN
  logic [CNT_W-1:0]  guard_num_q, guard_num_d;
  logic [CNT_W-1:0]  guard_cnt_q, guard_cnt_d;
  logic [ADDR_W-1:0] guard_addr_q, guard_addr_d;
  logic              gpend_valid_q, gpend_valid_d;
  logic [5:0]        gpend_data_q, gpend_data_d;

  assign guard_ready_o  = (state_q == RUN) && !gpend_valid_q && (guard_cnt_q != guard_num_q);
  assign guard_cnt_done = (guard_cnt_q == guard_num_q);
  assign gpend_valid    = gpend_valid_q;
  assign gpend_data     = gpend_data_q;
  assign guard_addr     = guard_addr_q;

  always_comb begin
    guard_num_d   = guard_num_q;
    guard_cnt_d   = guard_cnt_q;
    guard_addr_d  = guard_addr_q;
    gpend_valid_d = gpend_valid_q;
    gpend_data_d  = gpend_data_q;
    if (start_job) begin
      guard_num_d   = guard_num_i;
      guard_cnt_d   = '0;
      guard_addr_d  = guard_base_i;
      gpend_valid_d = 1'b0;
    end else begin
      if (guard_gnt) begin
        gpend_valid_d = 1'b0;
        guard_addr_d  = guard_addr_q + ADDR_ONE;
      end
      if (guard_valid_i && guard_ready_o) begin
        gpend_valid_d = 1'b1;
        gpend_data_d  = guard_i;
        guard_cnt_d   = guard_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      guard_num_q   <= '0;
      guard_cnt_q   <= '0;
      guard_addr_q  <= '0;
      gpend_valid_q <= 1'b0;
      gpend_data_q  <= '0;
    end else begin
      guard_num_q   <= guard_num_d;
      guard_cnt_q   <= guard_cnt_d;
      guard_addr_q  <= guard_addr_d;
      gpend_valid_q <= gpend_valid_d;
      gpend_data_q  <= gpend_data_d;
    end
  end
`else
  // Guard channel absent: accept and drop every guard.
  logic unused_guard;
  assign unused_guard   = ^{guard_i, guard_valid_i, guard_base_i, guard_num_i};
  assign guard_ready_o  = 1'b1;
  assign guard_cnt_done = 1'b1;
  assign gpend_valid    = 1'b0;
  assign gpend_data     = '0;
  assign guard_addr     = '0;
`endif

endmodule

// File: doc/fm_wb_collector.md
FM_WB_COLLECTOR -- requirements
Module: fm_wb_collector

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: memory word-address width.
REQ-002 SHALL have parameter CNT_W, default 16: byte/guard count width.
REQ-003 SHALL have port clk  input  1: single clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1: synchronous, active-low reset.
REQ-005 SHALL have port start_i  input  1: one-cycle job start, sampled only in IDLE.
REQ-006 SHALL have ports data_base_i/guard_base_i  input  ADDR_W each: region word addresses, latched on start.
REQ-007 SHALL have ports byte_num_i/guard_num_i  input  CNT_W each: expected write-back bytes/guards, latched on start.
REQ-008 SHALL have ports wb_data_i  input  8, wb_valid_i  input  1, wb_ready_o  output  1: PE-row write-back byte stream.
REQ-009 SHALL have ports guard_i  input  6, guard_valid_i  input  1, guard_ready_o  output  1: PE-row guard stream.
REQ-010 SHALL have ports mem_req_o  output  1, mem_addr_o  output  ADDR_W, mem_wdata_o  output  32, mem_be_o  output  4, mem_gnt_i  input  1: single shared write port.
REQ-011 SHALL have port done_o  output  1: one-cycle pulse at job completion; busy_o  output  1: high outside IDLE.

Function
REQ-012 SHALL implement states IDLE, RUN, FLUSH, DONE; IDLE->RUN on start_i; RUN->FLUSH when byte and guard counts reached; FLUSH->DONE when no write pending; DONE->IDLE unconditionally.
REQ-013 SHALL transfer a byte/guard only on valid&&ready in the same cycle; ready SHALL not depend combinationally on valid.
REQ-014 SHALL pack bytes little-endian (first byte in [7:0]) into a 4-byte pack register.
REQ-015 SHALL move a full pack register (or the final partial one) into a one-entry data-pending register; wb_ready_o SHALL be low when pack is full and pending is occupied, or when byte count reached, or outside RUN.
REQ-016 SHALL issue the final partial word with mem_be_o covering only written bytes and unused bytes zero; full words SHALL use mem_be_o=4'hF.
REQ-017 SHALL hold each guard in a one-entry guard-pending register written to guard_base+index as mem_wdata_o={26'b0,guard}, mem_be_o=4'hF; guard_ready_o SHALL be low while it is occupied, when guard count reached, or outside RUN.
REQ-018 SHALL hold mem_req_o, mem_addr_o, mem_wdata_o, mem_be_o stable until mem_gnt_i; a write completes in the cycle mem_gnt_i is high.
REQ-019 SHALL arbitrate round-robin when both pending registers are occupied; after a data grant guard wins the next conflict, and vice versa; first conflict after start goes to data.
REQ-020 SHALL post-increment data and guard addresses per granted write, wrapping modulo 2^ADDR_W.
REQ-021 SHALL allow a pending register to be refilled in the same cycle it is granted (zero-bubble streaming).
REQ-022 SHALL treat byte_num_i=0 / guard_num_i=0 as no writes on that channel; both zero gives RUN->FLUSH->DONE in consecutive cycles.
REQ-023 SHALL ignore start_i outside IDLE.
REQ-024 SHALL pulse done_o for exactly the DONE cycle.

Reset
REQ-025 SHALL on rst_n low: state IDLE, all counters/pack/pending registers cleared, mem_req_o=0, mem_addr_o=0, mem_wdata_o=0, mem_be_o=0, wb_ready_o=0, guard_ready_o=0, done_o=0, busy_o=0.
REQ-026 SHALL abandon any in-flight job on reset, including a request awaiting mem_gnt_i; no write issued after reset until a new start_i.

Configuration
REQ-027 SHALL compile the guard channel only when FM_WB_GUARD_EN is defined.
REQ-028 SHALL, without FM_WB_GUARD_EN, tie guard_ready_o=1, discard guard_i, ignore guard_num_i/guard_base_i, and complete on byte count alone; ports remain present.

Verification
REQ-029 SHALL cover: base 0x10, 8 bytes 0x01..0x08, gnt always 1 -> writes 0x04030201@0x10, 0x08070605@0x11, be F, done_o one cycle later.
REQ-030 SHALL cover: 6 bytes -> second write @base+1 wdata 0x00000605, be 4'h3.
REQ-031 SHALL cover: data and guard pending together, gnt every cycle -> alternating data/guard addresses, data first.
REQ-032 SHALL cover: gnt held low 10 cycles -> mem_* stable, wb_ready_o low after 4 more bytes, no byte lost.
REQ-033 SHALL cover: reset asserted while mem_req_o=1 -> next cycle all outputs zero, state IDLE, no write after.
REQ-034 SHALL cover: byte_num=0, guard_num=0 -> busy 3 cycles, done_o pulse, no mem_req_o.
